// File: rtl/neokeon_pkg.sv
// Shared constants and FSM encoding for the Neokeon round-state unloader.
package neokeon_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = 128;
  localparam int CNT_W           = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/neokeon_word_mux.sv
// Combinational selector: picks 32-bit word n of a 128-bit block, with word 0
// taken from the most significant end when MSW_FIRST is set.
module neokeon_word_mux
  import neokeon_pkg::*;
#(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic [BLOCK_W-1:0] i_block,
  input  logic [CNT_W-1:0]   i_sel,
  output logic [WORD_W-1:0]  o_word
);

  logic [CNT_W-1:0] w_sel;

  // With four words, counting from the top end is just the bitwise inverse.
  assign w_sel = MSW_FIRST ? ~i_sel : i_sel;

  always_comb begin
    o_word = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      if (w_sel == i[CNT_W-1:0]) o_word = i_block[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/neokeon_round_unloader.sv
// Captures a 128-bit Neokeon round state and streams it out as four 32-bit
// words over a valid/ready handshake. Optional byte parity: NEOKEON_UNLOAD_PARITY_EN.
module neokeon_round_unloader
  import neokeon_pkg::*;
#(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic               inClk,
  input  logic               inRstN,
  input  logic               inStart,
  input  logic [BLOCK_W-1:0] inData,
  output logic               outBusy,
  output logic               outValid,
  input  logic               inReady,
  output logic [WORD_W-1:0]  outWord,
  output logic               outLast,
  output logic               outDone
`ifdef NEOKEON_UNLOAD_PARITY_EN
  ,
  output logic [3:0]         outParity
`endif
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BLOCK_W-1:0] r_shadow, w_shadow_nxt;
  logic               r_done, w_done_nxt;
  logic               w_send;
  logic [WORD_W-1:0]  w_word;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // inStart is only looked at in IDLE, so a busy frame can never be clobbered.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (inStart) begin
          w_shadow_nxt = inData;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (inReady) begin
          if (r_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  neokeon_word_mux #(.MSW_FIRST(MSW_FIRST)) u_word_mux (
    .i_block (r_shadow),
    .i_sel   (r_cnt),
    .o_word  (w_word)
  );

  assign w_send   = (r_state == ST_SEND);
  assign outValid = w_send;
  assign outBusy  = w_send;
  assign outWord  = w_send ? w_word : '0;
  assign outLast  = w_send && (r_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
  assign outDone  = r_done;

`ifdef NEOKEON_UNLOAD_PARITY_EN
  function automatic logic [3:0] byte_parity(input logic [WORD_W-1:0] word);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^word[8*i +: 8];
    return p;
  endfunction

  // outWord is already zero outside SEND, so its parity is zero there too.
  assign outParity = byte_parity(outWord);
`endif

endmodule

// File: tb/tb_neokeon_round_unloader.sv
// Bench for neokeon_round_unloader: one MSW-first and one LSW-first instance
// driven in parallel, checked against tables, hand sequences and a frame model.
module tb_neokeon_round_unloader;

  logic         inClk = 1'b0;
  logic         inRstN;
  logic         inStart;
  logic [127:0] inData;
  logic         inReady;

  logic        b1, v1, l1, d1, b0, v0, l0, d0;
  logic [31:0] w1, w0;
  logic [3:0]  p1, p0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 inClk = ~inClk;

  neokeon_round_unloader #(.MSW_FIRST(1'b1)) dut_msw (
    .inClk(inClk), .inRstN(inRstN), .inStart(inStart), .inData(inData),
    .outBusy(b1), .outValid(v1), .inReady(inReady), .outWord(w1),
    .outLast(l1), .outDone(d1)
`ifdef NEOKEON_UNLOAD_PARITY_EN
    , .outParity(p1)
`endif
  );

  neokeon_round_unloader #(.MSW_FIRST(1'b0)) dut_lsw (
    .inClk(inClk), .inRstN(inRstN), .inStart(inStart), .inData(inData),
    .outBusy(b0), .outValid(v0), .inReady(inReady), .outWord(w0),
    .outLast(l0), .outDone(d0)
`ifdef NEOKEON_UNLOAD_PARITY_EN
    , .outParity(p0)
`endif
  );

`ifndef NEOKEON_UNLOAD_PARITY_EN
  assign p1 = 4'h0;
  assign p0 = 4'h0;
`endif

  // Reference model: a frame is a list of four words; an index walks it.
  bit           m_busy;
  int           m_idx;
  bit           m_done;
  logic [127:0] m_data;

  function automatic logic [31:0] word_of(input logic [127:0] d, input int idx, input bit msw);
    logic [127:0] sh;
    sh = msw ? (d >> (32 * (3 - idx))) : (d >> (32 * idx));
    return sh[31:0];
  endfunction

  function automatic logic [3:0] par_of(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_done = 0; m_data = '0;
  endtask

  task automatic model_edge(input logic s, input logic [127:0] d, input logic r);
    bit done_n;
    done_n = 0;
    if (!m_busy) begin
      if (s) begin m_data = d; m_idx = 0; m_busy = 1; end
    end else if (r) begin
      m_idx++;
      if (m_idx == 4) begin m_busy = 0; m_idx = 0; done_n = 1; end
    end
    m_done = done_n;
  endtask

  function automatic logic [31:0] exp_word(input bit msw);
    return m_busy ? word_of(m_data, m_idx, msw) : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic last_e;
    last_e = m_busy && (m_idx == 3);
    chk({tag, ".valid"}, v1, m_busy);
    chk({tag, ".busy"},  b1, m_busy);
    chk({tag, ".word"},  w1, exp_word(1));
    chk({tag, ".last"},  l1, last_e);
    chk({tag, ".done"},  d1, m_done);
    chk({tag, ".word_lsw"}, w0, exp_word(0));
    chk({tag, ".last_lsw"}, l0, last_e);
    chk({tag, ".done_lsw"}, d0, m_done);
`ifdef NEOKEON_UNLOAD_PARITY_EN
    chk({tag, ".par"},     p1, par_of(exp_word(1)));
    chk({tag, ".par_lsw"}, p0, par_of(exp_word(0)));
`endif
  endtask

  task automatic cyc(input logic s, input logic [127:0] d, input logic r);
    inStart = s; inData = d; inReady = r;
    @(posedge inClk);
    #1;
    model_edge(s, d, r);
    inStart = 1'b0;
  endtask

  typedef struct {
    logic         start;
    logic [127:0] data;
    logic         ready;
    logic         ev;
    logic [31:0]  ew;
    logic [31:0]  ew0;
    logic         el;
    logic         ed;
  } vec_t;

  localparam logic [127:0] D = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] F = {128{1'b1}};
  localparam logic [31:0]  W0 = 32'h00112233, W1 = 32'h44556677,
                           W2 = 32'h8899AABB, W3 = 32'hCCDDEEFF, WF = 32'hFFFFFFFF;

  function automatic vec_t mk(input logic s, input logic [127:0] d, input logic r,
                              input logic ev, input logic [31:0] ew, input logic [31:0] ew0,
                              input logic el, input logic ed);
    vec_t v;
    v.start = s; v.data = d; v.ready = r; v.ev = ev;
    v.ew = ew; v.ew0 = ew0; v.el = el; v.ed = ed;
    return v;
  endfunction

  vec_t tbl [27];

  initial begin
    // Basic frame, both word orders
    tbl[0]  = mk(1, D, 1, 1, W0, W3, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, W1, W2, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, W2, W1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, W3, W0, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0);
    // Back-pressure on word 1 for three cycles
    tbl[6]  = mk(1, D, 1, 1, W0, W3, 0, 0);
    tbl[7]  = mk(0, D, 1, 1, W1, W2, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, W1, W2, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, W1, W2, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, W1, W2, 0, 0);
    tbl[11] = mk(0, 0, 1, 1, W2, W1, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, W3, W0, 1, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    // inStart held high with new data mid-frame and on the word-3 transfer
    tbl[15] = mk(1, D, 1, 1, W0, W3, 0, 0);
    tbl[16] = mk(1, F, 1, 1, W1, W2, 0, 0);
    tbl[17] = mk(1, F, 1, 1, W2, W1, 0, 0);
    tbl[18] = mk(1, F, 1, 1, W3, W0, 1, 0);
    tbl[19] = mk(1, F, 1, 0, 0, 0, 0, 1);
    // Start accepted in the outDone cycle
    tbl[20] = mk(1, F, 1, 1, WF, WF, 0, 0);
    tbl[21] = mk(0, 0, 0, 1, WF, WF, 0, 0);
    tbl[22] = mk(0, 0, 1, 1, WF, WF, 0, 0);
    tbl[23] = mk(0, 0, 1, 1, WF, WF, 0, 0);
    tbl[24] = mk(0, 0, 1, 1, WF, WF, 1, 0);
    tbl[25] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tbl[26] = mk(0, 0, 1, 0, 0, 0, 0, 0);

    inRstN = 1'b0; inStart = 1'b0; inData = '0; inReady = 1'b0;
    model_reset();
    repeat (2) @(posedge inClk);
    #1;
    chk("rst.valid", v1, 1'b0); chk("rst.busy", b1, 1'b0);
    chk("rst.word", w1, 32'h0); chk("rst.last", l1, 1'b0);
    chk("rst.done", d1, 1'b0);  chk("rst.valid_lsw", v0, 1'b0);
`ifdef NEOKEON_UNLOAD_PARITY_EN
    chk("rst.par", p1, 4'h0);
`endif
    inRstN = 1'b1;
    @(posedge inClk); #1;
    check_model("idle");

    for (int i = 0; i < 27; i++) begin
      string nm;
      cyc(tbl[i].start, tbl[i].data, tbl[i].ready);
      nm = $sformatf("tbl%0d", i);
      chk({nm, ".valid"}, v1, tbl[i].ev);
      chk({nm, ".busy"},  b1, tbl[i].ev);
      chk({nm, ".word"},  w1, tbl[i].ew);
      chk({nm, ".last"},  l1, tbl[i].el);
      chk({nm, ".done"},  d1, tbl[i].ed);
      chk({nm, ".word_lsw"}, w0, tbl[i].ew0);
      chk({nm, ".last_lsw"}, l0, tbl[i].el);
      chk({nm, ".done_lsw"}, d0, tbl[i].ed);
    end

    // Asynchronous reset after the second transfer
    cyc(1, D, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("midrst.pre_word", w1, W2);
    inRstN = 1'b0;
    #1;
    model_reset();
    chk("midrst.valid", v1, 1'b0); chk("midrst.busy", b1, 1'b0);
    chk("midrst.word", w1, 32'h0); chk("midrst.last", l1, 1'b0);
    chk("midrst.done", d1, 1'b0);
    @(posedge inClk); #1;
    inRstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      check_model("postrst");
      chk("postrst.nodone", d1, 1'b0);
    end
    cyc(1, F, 0);
    chk("fresh.word", w1, WF);
    chk("fresh.last", l1, 1'b0);
    check_model("fresh");
    for (int i = 0; i < 5; i++) begin cyc(0, 0, 1); check_model("fresh"); end

`ifdef NEOKEON_UNLOAD_PARITY_EN
    cyc(1, {32'h01030700, 96'h0}, 0);
    chk("par.word0", w1, 32'h01030700);
    chk("par.bits", p1, 4'b1010);
    for (int i = 0; i < 5; i++) begin cyc(0, 0, 1); check_model("par"); end
`endif

    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 3) == 0,
          {$urandom(), $urandom(), $urandom(), $urandom()},
          $urandom_range(0, 2) != 0);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neokeon_round_unloader.md
NEOKEON_ROUND_UNLOADER -- requirements
Module: neokeon_round_unloader

Interface
REQ-001 SHALL have parameter MSW_FIRST, default 1, meaning that word 0 is inData[127:96] when 1 and inData[31:0] when 0.
REQ-002 SHALL have port inClk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port inRstN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port inStart, input, 1, active-high request to capture inData and begin unloading.
REQ-005 SHALL have port inData, input, 128, the Neokeon round-register state to be read out.
REQ-006 SHALL have port outBusy, output, 1, high from the capture edge until the final word handshake completes.
REQ-007 SHALL have port outValid, output, 1, high while outWord holds a word not yet accepted.
REQ-008 SHALL have port inReady, input, 1, sink acceptance; a transfer occurs on a rising edge with outValid=1 and inReady=1.
REQ-009 SHALL have port outWord, output, 32, the current word of the captured state.
REQ-010 SHALL have port outLast, output, 1, high together with outValid on word 3 only.
REQ-011 SHALL have port outDone, output, 1, one-cycle pulse on the cycle after the word-3 transfer.

Function
REQ-012 SHALL implement FSM states IDLE and SEND; reset state IDLE.
REQ-013 SHALL, in IDLE with inStart=1, capture inData into a 128-bit shadow register, clear the word counter, and enter SEND on the same edge.
REQ-014 SHALL assert outValid=1 exactly in SEND, so the first word is presented 1 cycle after the inStart edge.
REQ-015 SHALL hold outWord, outLast and the counter stable while outValid=1 and inReady=0.
REQ-016 SHALL increment the 2-bit counter on each transfer, and return to IDLE on the transfer of word 3 (counter 3), with no wrap to word 0.
REQ-017 SHALL ignore inStart while outBusy=1, including in the cycle of the word-3 transfer; the shadow register is not overwritten.
REQ-018 SHALL drive outWord from the shadow register only, so changes on inData after capture have no effect.
REQ-019 SHALL drive outWord=0 and outLast=0 whenever outValid=0.
REQ-020 SHALL accept a new inStart in the cycle outDone is high, which starts back-to-back frames with one idle cycle between them.

Reset
REQ-021 SHALL, on inRstN=0, immediately force IDLE, counter=0, shadow=0, outBusy=0, outValid=0, outWord=0, outLast=0 and outDone=0.
REQ-022 SHALL, on reset in the middle of a frame, abandon the frame with no outDone pulse and no resumption after reset.

Configuration
REQ-023 SHALL, with NEOKEON_UNLOAD_PARITY_EN defined, add output outParity (4 bits): bit i is the even parity (XOR) of outWord byte i, and is 0 when outValid=0 or during reset.
REQ-024 SHALL, without NEOKEON_UNLOAD_PARITY_EN, have no outParity port and no parity logic, with all other behaviour identical.

Structure
REQ-025 SHALL place the FSM state encoding, the word width (32), the words-per-block count (4) and the block width (128) in a shared package, neokeon_pkg.
REQ-026 SHALL use one sub-module, neokeon_word_mux, which is purely combinational and selects 32-bit word n of 128 bits per MSW_FIRST; all sequential logic stays in the top module.

Verification
REQ-027 SHALL cover this case: inData=0x00112233_44556677_8899AABB_CCDDEEFF, one-cycle inStart, inReady=1 -> outWord is 00112233, 44556677, 8899AABB, CCDDEEFF on cycles 1-4; outLast is set on cycle 4; outDone pulses on cycle 5; outBusy covers cycles 1-4.
REQ-028 SHALL cover this case: same data, inReady=0 for cycles 2-4 -> outWord holds 44556677 through those cycles; the frame ends with exactly 4 transfers; outDone appears 3 cycles later than in REQ-027.
REQ-029 SHALL cover this case: inStart pulsed again on cycle 2 with inData=0xFFFF...FFFF -> it is ignored, and the original four words are delivered unchanged.
REQ-030 SHALL cover this case: inRstN=0 after the second transfer -> all outputs go to 0 immediately, there is no outDone, and a following inStart begins a fresh frame at word 0.
REQ-031 SHALL cover this case: MSW_FIRST=0 with the REQ-027 data -> the order is CCDDEEFF, 8899AABB, 44556677, 00112233, with outLast on 00112233.
REQ-032 SHALL cover this case: NEOKEON_UNLOAD_PARITY_EN defined and inData[127:96]=0x01030700 -> outParity=4'b1010 on word 0, where byte 0x00 gives bit0=0, byte 0x07 gives bit1=1, byte 0x03 gives bit2=0 and byte 0x01 gives bit3=1.
